// File: rtl/counter_run_ctrl.sv
// counter_run_ctrl
// Run controller for a CNT_W-bit wrapping counter with enable and
// synchronous clear. One accepted start clears the counter, then enables it
// for exactly cfg_wraps*2^CNT_W + cfg_final cycles. The counter is left
// holding the final value and done pulses once. An abort via stop ends the
// run early and pulses done together with err.
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   start              run request, only looked at in IDLE
//   stop               abort request, only looked at in CLEAR/RUN
//   pause              level, suspends counting while in RUN
//   cfg_wraps/final    run length, latched on an accepted start
//   cnt_in, cout_in    counter value and carry (carry = cnt_in all-ones)
//   cnt_en, cnt_clr    counter enable (combinational) and clear
//   busy, done, err    status; done/err are one-cycle pulses
//   wraps_seen         full wraps counted in the current/last run
module counter_run_ctrl #(
    parameter int CNT_W  = 4,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic [WRAP_W-1:0] cfg_wraps,
    input  logic [CNT_W-1:0]  cfg_final,
    input  logic [CNT_W-1:0]  cnt_in,
    input  logic              cout_in,
    output logic              cnt_en,
    output logic              cnt_clr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [WRAP_W-1:0] wraps_seen
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_RUN, S_DONE, S_ABORT
    } state_t;

    typedef struct packed {
        logic [WRAP_W-1:0] wraps;
        logic [CNT_W-1:0]  fin;
    } tgt_t;

    state_t state;
    tgt_t   tgt;
    logic   at_target;

    // The run is complete once both the wrap tally and the live counter
    // value match the latched target. This also stops the enable, so the
    // tally can never overshoot tgt.wraps.
    assign at_target = (wraps_seen == tgt.wraps) && (cnt_in == tgt.fin);

    // Enable must respond in the same cycle the target is reached, so it
    // is decoded combinationally instead of registered.
    assign cnt_en = (state == S_RUN) && !pause && !at_target;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            tgt        <= '0;
            wraps_seen <= '0;
            cnt_clr    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            // Pulses default low; set only on the edge entering their state.
            cnt_clr <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tgt.wraps <= cfg_wraps;
                        tgt.fin   <= cfg_final;
                        cnt_clr   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    wraps_seen <= '0;
                    if (stop) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= S_ABORT;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // A carry only counts when the counter actually advances.
                    if (cnt_en && cout_in)
                        wraps_seen <= wraps_seen + 1'b1;
                    // Completion takes priority over a same-cycle stop.
                    if (at_target) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (stop) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= S_ABORT;
                    end
                end
                S_DONE, S_ABORT: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_run_ctrl.sv
module tb_counter_run_ctrl;

    localparam int CNT_W  = 4;
    localparam int WRAP_W = 8;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic [WRAP_W-1:0] cfg_wraps = '0;
    logic [CNT_W-1:0]  cfg_final = '0;
    logic [CNT_W-1:0]  cnt;
    logic              cout;
    logic              cnt_en, cnt_clr, busy, done, err;
    logic [WRAP_W-1:0] wraps_seen;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    counter_run_ctrl #(.CNT_W(CNT_W), .WRAP_W(WRAP_W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .stop(stop), .pause(pause),
        .cfg_wraps(cfg_wraps), .cfg_final(cfg_final), .cnt_in(cnt), .cout_in(cout),
        .cnt_en(cnt_en), .cnt_clr(cnt_clr), .busy(busy), .done(done), .err(err),
        .wraps_seen(wraps_seen)
    );

    // Counter being controlled: wrapping, enable + synchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      cnt <= '0;
        else if (cnt_clr) cnt <= '0;
        else if (cnt_en)  cnt <= cnt + 1'b1;
    end
    assign cout = &cnt;

    // After return we sit 1 time unit past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one start..done sequence. Loop iteration c is the cycle after
    // edge E(c-1); done_cyc = c means done was first seen after edge Ec.
    // pause_at/stop_cnt < 0 disable them; stop_cnt == -2 stops in CLEAR.
    task automatic do_run(input int w, input int f, input int pause_at, input int pause_len,
                          input int stop_cnt, input int stop_wr,
                          output int done_cyc, output int en_cnt, output logic err_d,
                          output logic en_d, output logic pause_ok, output logic post_ok);
        int  plen;
        bit  pused;
        done_cyc = -1; en_cnt = 0; err_d = 0; en_d = 0; pause_ok = 1; post_ok = 0;
        plen = 0; pused = 0;
        cfg_wraps = WRAP_W'(w); cfg_final = CNT_W'(f); start = 1;
        step();
        start = 0;
        for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
            if (pause_at >= 0 && !pused && busy && !cnt_clr && int'(cnt) == pause_at) begin
                plen = pause_len; pused = 1;
            end
            pause = (plen > 0);
            if (plen > 0) plen--;
            stop = 0;
            if (stop_cnt == -2 && cnt_clr) stop = 1;
            if (stop_cnt >= 0 && busy && !cnt_clr && int'(cnt) == stop_cnt &&
                int'(wraps_seen) == stop_wr) stop = 1;
            #1;
            if (pause && cnt_en) pause_ok = 0;
            if (cnt_en) en_cnt++;
            step();
            if (done) begin
                done_cyc = c; err_d = err; en_d = cnt_en;
            end
        end
        stop = 0; pause = 0;
        step();
        post_ok = !done && !err && !busy && !cnt_en;
    endtask

    task automatic test_reset();
        int nbad = 0;
        resetn = 0;
        for (int i = 0; i < 8; i++) begin
            start = 1'($urandom); stop = 1'($urandom); pause = 1'($urandom);
            cfg_wraps = WRAP_W'($urandom); cfg_final = CNT_W'($urandom);
            step();
            if ({cnt_en, cnt_clr, busy, done, err} !== 5'b0 || wraps_seen !== '0) nbad++;
        end
        total++;
        if (nbad != 0) begin
            bad++; $display("FAIL reset_outputs: %0d cycles nonzero, want 0", nbad);
        end
        start = 0; stop = 0; pause = 0; cfg_wraps = '0; cfg_final = '0;
        resetn = 1;
        nbad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (busy || cnt_clr || cnt_en || done) nbad++;
        end
        total++;
        if (nbad != 0) begin
            bad++; $display("FAIL reset_idle: %0d active cycles, want 0", nbad);
        end
    endtask

    task automatic test_normal();
        int dc, en, nbad;
        logic e, ed, pok, post;
        do_run(2, 5, -1, 0, -1, 0, dc, en, e, ed, pok, post);
        total++; if (dc !== 39) begin bad++; $display("FAIL normal_done_cycle: got %0d want 39", dc); end
        total++; if (en !== 37) begin bad++; $display("FAIL normal_en_cycles: got %0d want 37", en); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL normal_err: got %0b want 0", e); end
        total++; if (post !== 1'b1) begin bad++; $display("FAIL normal_post_idle: got %0b want 1", post); end
        total++; if (wraps_seen !== 8'd2) begin bad++; $display("FAIL normal_wraps: got %0d want 2", wraps_seen); end
        nbad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cnt !== 4'd5 || cnt_en || cnt_clr) nbad++;
        end
        total++; if (nbad != 0) begin bad++; $display("FAIL normal_hold: %0d bad cycles, want 0 (cnt=%0d want 5)", nbad, cnt); end
    endtask

    task automatic test_zero();
        int dc, en;
        logic e, ed, pok, post;
        do_run(0, 0, -1, 0, -1, 0, dc, en, e, ed, pok, post);
        total++; if (dc !== 2) begin bad++; $display("FAIL zero_done_cycle: got %0d want 2", dc); end
        total++; if (en !== 0) begin bad++; $display("FAIL zero_en_cycles: got %0d want 0", en); end
        total++; if (wraps_seen !== 8'd0) begin bad++; $display("FAIL zero_wraps: got %0d want 0", wraps_seen); end
        total++; if (e !== 1'b0 || post !== 1'b1) begin bad++; $display("FAIL zero_err_post: got err=%0b post=%0b want 0 1", e, post); end
    endtask

    task automatic test_pause();
        int dc, en;
        logic e, ed, pok, post;
        // Unpaused length is N=19, done after E21; ten pause cycles add ten.
        do_run(1, 3, 8, 10, -1, 0, dc, en, e, ed, pok, post);
        total++; if (dc !== 31) begin bad++; $display("FAIL pause_done_cycle: got %0d want 31", dc); end
        total++; if (en !== 19) begin bad++; $display("FAIL pause_en_cycles: got %0d want 19", en); end
        total++; if (pok !== 1'b1) begin bad++; $display("FAIL pause_gates_en: got %0b want 1", pok); end
        total++; if (wraps_seen !== 8'd1 || cnt !== 4'd3) begin bad++; $display("FAIL pause_final: got w=%0d c=%0d want 1 3", wraps_seen, cnt); end
        // Pause across the carry at 15: the wrap must not be counted early.
        do_run(1, 3, 15, 4, -1, 0, dc, en, e, ed, pok, post);
        total++; if (dc !== 25 || wraps_seen !== 8'd1) begin bad++; $display("FAIL pause_at_carry: got dc=%0d w=%0d want 25 1", dc, wraps_seen); end
    endtask

    task automatic test_abort();
        int dc, en;
        logic e, ed, pok, post;
        // stop raised while cnt=8; that cycle still counts, so it halts at 9.
        do_run(1, 3, -1, 0, 8, 0, dc, en, e, ed, pok, post);
        total++; if (dc !== 10 || e !== 1'b1) begin bad++; $display("FAIL abort_done_err: got dc=%0d err=%0b want 10 1", dc, e); end
        total++; if (ed !== 1'b0 || post !== 1'b1) begin bad++; $display("FAIL abort_en_low: got en=%0b post=%0b want 0 1", ed, post); end
        total++; if (cnt !== 4'd9 || wraps_seen !== 8'd0) begin bad++; $display("FAIL abort_hold: got c=%0d w=%0d want 9 0", cnt, wraps_seen); end
        // stop coincident with at_target: completion wins.
        do_run(1, 3, -1, 0, 3, 1, dc, en, e, ed, pok, post);
        total++; if (dc !== 21 || e !== 1'b0) begin bad++; $display("FAIL abort_vs_target: got dc=%0d err=%0b want 21 0", dc, e); end
        // stop during CLEAR.
        do_run(2, 5, -1, 0, -2, 0, dc, en, e, ed, pok, post);
        total++; if (dc !== 1 || e !== 1'b1 || en !== 0) begin bad++; $display("FAIL abort_in_clear: got dc=%0d err=%0b en=%0d want 1 1 0", dc, e, en); end
        total++; if (cnt !== 4'd0 || wraps_seen !== 8'd0) begin bad++; $display("FAIL abort_clear_state: got c=%0d w=%0d want 0 0", cnt, wraps_seen); end
    endtask

    task automatic test_back_to_back();
        int dc, n;
        dc = -1;
        cfg_wraps = 8'd0; cfg_final = 4'd5; start = 1;
        step();
        start = 0;
        for (int c = 1; c <= 50 && dc < 0; c++) begin
            if (c >= 2 && c <= 4) begin
                start = 1; cfg_wraps = 8'd3; cfg_final = 4'd9;
            end else begin
                start = 0;
            end
            step();
            if (done) dc = c;
        end
        total++; if (dc !== 7 || cnt !== 4'd5 || wraps_seen !== 8'd0) begin bad++; $display("FAIL busy_start_ignored: got dc=%0d c=%0d w=%0d want 7 5 0", dc, cnt, wraps_seen); end
        // In DONE now; a start held from here is taken one edge after IDLE.
        start = 1; cfg_wraps = 8'd0; cfg_final = 4'd2;
        step();
        total++; if (cnt_clr !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL restart_too_early: got clr=%0b busy=%0b want 0 0", cnt_clr, busy); end
        step();
        start = 0;
        total++; if (cnt_clr !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL restart_accept: got clr=%0b busy=%0b want 1 1", cnt_clr, busy); end
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (done) begin n = i; break; end
        end
        total++; if (n !== 4 || cnt !== 4'd2) begin bad++; $display("FAIL restart_run: got n=%0d c=%0d want 4 2", n, cnt); end
    endtask

    task automatic test_midrun_reset();
        int dc, en, nd;
        logic e, ed, pok, post;
        step(); step();
        cfg_wraps = 8'd1; cfg_final = 4'd0; start = 1;
        step();
        start = 0;
        for (int i = 0; i < 6; i++) step();
        resetn = 0;
        #1;
        total++; if ({busy, done, err, cnt_en, cnt_clr} !== 5'b0 || wraps_seen !== '0) begin bad++; $display("FAIL midrun_reset: got b=%0b d=%0b en=%0b w=%0d want all 0", busy, done, cnt_en, wraps_seen); end
        nd = 0;
        for (int i = 0; i < 3; i++) begin step(); if (done) nd++; end
        resetn = 1;
        for (int i = 0; i < 3; i++) begin step(); if (done || busy) nd++; end
        total++; if (nd != 0) begin bad++; $display("FAIL midrun_no_done: got %0d want 0", nd); end
        do_run(0, 2, -1, 0, -1, 0, dc, en, e, ed, pok, post);
        total++; if (dc !== 4 || en !== 2 || e !== 1'b0 || cnt !== 4'd2) begin bad++; $display("FAIL post_reset_run: got dc=%0d en=%0d err=%0b c=%0d want 4 2 0 2", dc, en, e, cnt); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_zero();
        test_pause();
        test_abort();
        test_back_to_back();
        test_midrun_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
